// File: rtl/minmax_pkg.sv
// Shared widths and FSM state encoding for the min/max frame tracker.
package minmax_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACC    = 2'd1,
        RESULT = 2'd2
    } state_t;

endpackage

// File: rtl/minmax_cmp.sv
// Combinational signed/unsigned magnitude compare of i_a against i_b.
module minmax_cmp
    import minmax_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_sign,
    output logic              o_gr,
    output logic              o_lt,
    output logic              o_eq
);

    // One extra bit lets one signed comparator serve both modes.
    logic signed [DATA_W:0] w_a_ext;
    logic signed [DATA_W:0] w_b_ext;

    assign w_a_ext = {i_sign & i_a[DATA_W-1], i_a};
    assign w_b_ext = {i_sign & i_b[DATA_W-1], i_b};

    assign o_gr = (w_a_ext >  w_b_ext);
    assign o_lt = (w_a_ext <  w_b_ext);
    assign o_eq = (w_a_ext == w_b_ext);

endmodule

// File: rtl/minmax_tracker32.sv
// Per-frame min/max/count tracker with ready/valid handshakes on both sides.
// Define MINMAX_INDEX_EN to add first-occurrence position outputs for min and max.
module minmax_tracker32
    import minmax_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sign,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic [CNT_W-1:0]  out_count,
    output logic              gr,
    output logic              lt,
    output logic              eq
`ifdef MINMAX_INDEX_EN
    ,
    output logic [CNT_W-1:0]  out_min_idx,
    output logic [CNT_W-1:0]  out_max_idx
`endif
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    state_t              r_state;
    logic                r_sign;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_min;
    logic [DATA_W-1:0]   r_max;
    logic [CNT_W-1:0]    r_count;
    logic                r_gr;
    logic                r_lt;
    logic                r_eq;
`ifdef MINMAX_INDEX_EN
    logic [CNT_W-1:0]    r_min_idx;
    logic [CNT_W-1:0]    r_max_idx;
`endif

    logic w_xfer, w_ohs;
    logic w_max_gr, w_max_lt, w_max_eq;
    logic w_min_gr, w_min_lt, w_min_eq;
    logic w_upd_max, w_upd_min;

    minmax_cmp u_cmp_max (
        .i_a    (in_data),
        .i_b    (r_max),
        .i_sign (r_sign),
        .o_gr   (w_max_gr),
        .o_lt   (w_max_lt),
        .o_eq   (w_max_eq)
    );

    minmax_cmp u_cmp_min (
        .i_a    (in_data),
        .i_b    (r_min),
        .i_sign (r_sign),
        .o_gr   (w_min_gr),
        .o_lt   (w_min_lt),
        .o_eq   (w_min_eq)
    );

    // Strict inequality only, so ties keep the first occurrence.
    assign w_upd_max = ~(w_max_lt | w_max_eq);
    assign w_upd_min = ~(w_min_gr | w_min_eq);

    assign in_ready  = (r_state != RESULT) & ~rst;
    assign w_xfer    = in_valid & in_ready;
    assign w_ohs     = r_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_sign      <= 1'b0;
            r_out_valid <= 1'b0;
            r_min       <= '0;
            r_max       <= '0;
            r_count     <= '0;
            r_gr        <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
`ifdef MINMAX_INDEX_EN
            r_min_idx   <= '0;
            r_max_idx   <= '0;
`endif
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_xfer) begin
                        r_sign      <= sign;
                        r_min       <= in_data;
                        r_max       <= in_data;
                        r_count     <= {{(CNT_W-1){1'b0}}, 1'b1};
                        r_gr        <= 1'b0;
                        r_lt        <= 1'b0;
                        r_eq        <= 1'b1;
`ifdef MINMAX_INDEX_EN
                        r_min_idx   <= '0;
                        r_max_idx   <= '0;
`endif
                        r_state     <= in_last ? RESULT : ACC;
                        r_out_valid <= in_last;
                    end
                end
                ACC: begin
                    if (w_xfer) begin
                        if (w_upd_max) r_max <= in_data;
                        if (w_upd_min) r_min <= in_data;
`ifdef MINMAX_INDEX_EN
                        if (w_upd_max) r_max_idx <= r_count;
                        if (w_upd_min) r_min_idx <= r_count;
`endif
                        r_count     <= sat_inc(r_count);
                        r_gr        <= w_max_gr;
                        r_lt        <= w_min_lt;
                        r_eq        <= w_max_eq & w_min_eq;
                        r_state     <= in_last ? RESULT : ACC;
                        r_out_valid <= in_last;
                    end
                end
                RESULT: begin
                    if (w_ohs) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_min   = r_min;
    assign out_max   = r_max;
    assign out_count = r_count;
    assign gr        = r_gr;
    assign lt        = r_lt;
    assign eq        = r_eq;
`ifdef MINMAX_INDEX_EN
    assign out_min_idx = r_min_idx;
    assign out_max_idx = r_max_idx;
`endif

endmodule

// File: tb/tb_minmax_tracker32.sv
// Directed bench for minmax_tracker32; index checks compile in with MINMAX_INDEX_EN.
module tb_minmax_tracker32;

    logic        clk = 1'b0;
    logic        rst;
    logic        sign;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_min;
    logic [31:0] out_max;
    logic [15:0] out_count;
    logic        gr, lt, eq;
`ifdef MINMAX_INDEX_EN
    logic [15:0] out_min_idx, out_max_idx;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    minmax_tracker32 dut (
        .clk       (clk),
        .rst       (rst),
        .sign      (sign),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_min   (out_min),
        .out_max   (out_max),
        .out_count (out_count),
        .gr        (gr),
        .lt        (lt),
        .eq        (eq)
`ifdef MINMAX_INDEX_EN
        ,
        .out_min_idx (out_min_idx),
        .out_max_idx (out_max_idx)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic [31:0] mn, input logic [31:0] mx,
                             input logic [15:0] cnt, input logic g, input logic l, input logic e);
        check({tag, "_min"}, out_min, mn);
        check({tag, "_max"}, out_max, mx);
        check({tag, "_cnt"}, {16'h0, out_count}, {16'h0, cnt});
        check({tag, "_rel"}, {29'h0, gr, lt, eq}, {29'h0, g, l, e});
    endtask

    // Offers one sample, returns at the negedge right after the transfer edge.
    task automatic send(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_rdy_timeout", {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'hDEADBEEF;
    endtask

    task automatic take(input string tag);
        check({tag, "_ovld"}, {31'h0, out_valid}, 32'h1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_rdy_after_hs"}, {31'h0, in_ready}, 32'h1);
        check({tag, "_ovld_after_hs"}, {31'h0, out_valid}, 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold_min;
        rst = 1'b1; sign = 1'b0; in_valid = 1'b0; in_data = 32'h0;
        in_last = 1'b0; out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rdy", {31'h0, in_ready}, 32'h0);
        check("rst_ovld", {31'h0, out_valid}, 32'h0);
        check_res("rst", 32'h0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0);
`ifdef MINMAX_INDEX_EN
        check("rst_idx", {out_min_idx, out_max_idx}, 32'h0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("rst_rel_rdy", {31'h0, in_ready}, 32'h1);

        // Signed frame {5, -3, 7}
        sign = 1'b1;
        send(32'd5, 1'b0);
        check("s_mid_ovld", {31'h0, out_valid}, 32'h0);
        send(32'hFFFFFFFD, 1'b0);
        send(32'd7, 1'b1);
        check("s_rdy_res", {31'h0, in_ready}, 32'h0);
        check_res("s", 32'hFFFFFFFD, 32'd7, 16'd3, 1'b1, 1'b0, 1'b0);
        take("s");

        // Unsigned frame, sign flipped after first sample must not matter
        sign = 1'b0;
        send(32'd5, 1'b0);
        sign = 1'b1;
        send(32'hFFFFFFFD, 1'b0);
        send(32'd7, 1'b1);
        check_res("u", 32'd5, 32'hFFFFFFFD, 16'd3, 1'b0, 1'b0, 1'b0);
        take("u");

        // Single sample frame, then hold in RESULT for 10 cycles
        sign = 1'b0;
        send(32'h12345678, 1'b1);
        check_res("one", 32'h12345678, 32'h12345678, 16'd1, 1'b0, 1'b0, 1'b1);
`ifdef MINMAX_INDEX_EN
        check("one_idx", {out_min_idx, out_max_idx}, 32'h0);
`endif
        hold_min = out_min;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h00000001 + i;
            in_last  = i[0];
            sign     = ~sign;
            @(negedge clk);
            check("hold_rdy", {31'h0, in_ready}, 32'h0);
            check("hold_ovld", {31'h0, out_valid}, 32'h1);
            check("hold_min", out_min, hold_min);
            check("hold_cnt", {16'h0, out_count}, 32'd1);
        end
        in_valid = 1'b0; in_last = 1'b0;
        check_res("hold_end", 32'h12345678, 32'h12345678, 16'd1, 1'b0, 1'b0, 1'b1);
        take("hold");

        // Sign-mode ordering of 0x80000000 vs 0x7FFFFFFF
        sign = 1'b1;
        send(32'h7FFFFFFF, 1'b0);
        send(32'h80000000, 1'b1);
        check_res("bs", 32'h80000000, 32'h7FFFFFFF, 16'd2, 1'b0, 1'b1, 1'b0);
        take("bs");
        sign = 1'b0;
        send(32'h7FFFFFFF, 1'b0);
        send(32'h80000000, 1'b1);
        check_res("bu", 32'h7FFFFFFF, 32'h80000000, 16'd2, 1'b1, 1'b0, 1'b0);
        take("bu");

        // Ties keep first occurrence
        send(32'd4, 1'b0);
        send(32'd9, 1'b0);
        send(32'd4, 1'b0);
        send(32'd9, 1'b1);
        check_res("tie", 32'd4, 32'd9, 16'd4, 1'b0, 1'b0, 1'b0);
`ifdef MINMAX_INDEX_EN
        check("tie_min_idx", {16'h0, out_min_idx}, 32'd0);
        check("tie_max_idx", {16'h0, out_max_idx}, 32'd1);
`endif
        take("tie");
        send(32'd3, 1'b0);
        send(32'd3, 1'b1);
        check_res("eq2", 32'd3, 32'd3, 16'd2, 1'b0, 1'b0, 1'b1);
        take("eq2");

        // Reset mid-frame discards partial result
        send(32'd10, 1'b0);
        send(32'd20, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_rdy", {31'h0, in_ready}, 32'h0);
        check("mrst_ovld", {31'h0, out_valid}, 32'h0);
        check_res("mrst", 32'h0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        send(32'd1, 1'b1);
        check_res("post_rst", 32'd1, 32'd1, 16'd1, 1'b0, 1'b0, 1'b1);
        take("post_rst");

        // Count saturation with min/max still updating afterwards
        sign = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 65537; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 65535) ? 32'd5 : ((i == 65536) ? 32'hFFFFFFFF : 32'd100);
            in_last  = (i == 65536);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        check_res("sat", 32'd5, 32'hFFFFFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        take("sat");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/minmax_tracker32.md
MINMAX_TRACKER32 -- requirements
Module: minmax_tracker32

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports listed clock first, then reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 sign  input  1  1 = two's-complement compare, 0 = unsigned; sampled on the first accepted sample of a frame.
REQ-005 in_valid  input  1  sample offered.
REQ-006 in_ready  output  1  block accepts sample this cycle.
REQ-007 in_data  input  32  sample value.
REQ-008 in_last  input  1  qualifies the final sample of a frame.
REQ-009 out_valid  output  1  frame result available.
REQ-010 out_ready  input  1  result consumer accepts.
REQ-011 out_min / out_max  output  32 each  smallest and largest sample of the frame.
REQ-012 out_count  output  16  samples accepted in the frame, saturating at 16'hFFFF.
REQ-013 gr / lt / eq  output  1 each  relation of the most recently accepted sample to the running max (gr), running min (lt), and both (eq = equal to both).

Function
REQ-014 A transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge; an output handshake SHALL occur when out_valid and out_ready are both 1.
REQ-015 The FSM SHALL have three states: EMPTY (no sample yet), ACC (frame open) and RESULT (result held).
REQ-016 EMPTY, first transfer: min = max = in_data, count = 1, sign latched, gr = lt = 0, eq = 1; next state ACC, or RESULT if in_last.
REQ-017 ACC, each transfer: min/max SHALL update under the latched sign mode; count increments; next state RESULT if in_last, else ACC.
REQ-018 A sample equal to the current min or max SHALL leave that register unchanged.
REQ-019 Signed mode SHALL order 32'h80000000 below 32'h7FFFFFFF; unsigned mode SHALL order them the reverse way.
REQ-020 in_ready SHALL be 1 in EMPTY and ACC and 0 in RESULT; out_valid SHALL be 1 only in RESULT.
REQ-021 out_valid SHALL assert on the cycle after the in_last transfer; latency is one cycle.
REQ-022 While in RESULT, out_min, out_max, out_count, gr, lt and eq SHALL hold stable until the output handshake; a change of sign SHALL have no effect.
REQ-023 On the output handshake, the block SHALL go to EMPTY; in_ready SHALL be 1 on the next cycle, giving one bubble cycle between frames.
REQ-024 Once count reaches 16'hFFFF, further transfers SHALL leave count at 16'hFFFF while still updating min and max.
REQ-025 Any in_data is valid while in_valid = 0 and SHALL be ignored.

Reset
REQ-026 When rst = 1 at a clock edge, the block SHALL go to EMPTY and clear all outputs: out_valid = 0, out_min = out_max = 0, out_count = 0, gr = lt = eq = 0.
REQ-027 in_ready SHALL be 0 while rst = 1 and SHALL go to 1 on the first cycle after rst deasserts.
REQ-028 Reset mid-frame or in RESULT SHALL discard the partial or pending result with no output handshake.

Configuration
REQ-029 With MINMAX_INDEX_EN defined, the block SHALL add outputs out_min_idx and out_max_idx (16 bits each), giving the zero-based frame position of the first occurrence of the min and of the max; both reset to 0 and hold in RESULT.
REQ-030 Without MINMAX_INDEX_EN, these ports and their registers SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-031 A shared package minmax_pkg SHALL hold DATA_W = 32, CNT_W = 16 and the FSM state enum (EMPTY, ACC, RESULT).
REQ-032 A combinational sub-module minmax_cmp SHALL produce gr/lt/eq for two 32-bit operands plus sign, and SHALL be instantiated twice: sample vs max, and sample vs min.

Verification
REQ-033 sign = 1, frame {5, -3, 7 (last)}: out_valid one cycle after the last transfer; min = 32'hFFFFFFFD, max = 7, count = 3.
REQ-034 sign = 0, same frame: min = 5, max = 32'hFFFFFFFD, count = 3.
REQ-035 Single-sample frame 32'h12345678 with in_last: min = max = 32'h12345678, count = 1, eq = 1; with MINMAX_INDEX_EN, min_idx = max_idx = 0.
REQ-036 out_ready held 0 for 10 cycles in RESULT: outputs stable, in_ready = 0; after the handshake, in_ready = 1 on the next cycle.
REQ-037 rst pulsed after two samples of a frame: all outputs 0 and state EMPTY; a new frame {1 (last)} yields count = 1.
REQ-038 Frame {4, 9, 4, 9 (last)} with MINMAX_INDEX_EN: min_idx = 0, max_idx = 1, count = 4.
